// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM state types
// shared by the sequential ALU and its shifter.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SLL = 3'd3,
    ALU_SRL = 3'd4,
    ALU_XOR = 3'd5,
    ALU_AND = 3'd6,
    ALU_OR  = 3'd7
  } alu_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_shift(
    input alu_op_t op
  );
    return (op == ALU_SLL) ||
           (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_seq_shift_unit.sv
// alu_shift_unit: iterative 1-bit/cycle shifter.
// Used when ALU_BARREL_SHIFT_EN is undefined.
module alu_shift_unit #(
  parameter int W  = 8,
  parameter int SW = $clog2(W) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_step,
  input  logic          i_left,
  input  logic [W-1:0]  i_din,
  input  logic [SW-1:0] i_amt,
  output logic          o_busy,
  output logic          o_finish,
  output logic [W-1:0]  o_next,
  output logic          o_next_bit
);

  logic [W-1:0]  r_sreg;
  logic [SW-1:0] r_cnt;
  logic          r_left;

  // Load operand and count, then shift one bit per step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
    end else if (i_load) begin
      r_sreg <= i_din;
      r_cnt  <= i_amt;
      r_left <= i_left;
    end else if (i_step && o_busy) begin
      r_sreg <= o_next;
      r_cnt  <= r_cnt - SW'(1);
    end
  end

  assign o_busy   = (r_cnt != '0);
  assign o_finish = (r_cnt == SW'(1));

  // Value and bit-out of the next shift step.
  assign o_next = r_left
    ? {r_sreg[W-2:0], 1'b0}
    : {1'b0, r_sreg[W-1:1]};
  assign o_next_bit = r_left
    ? r_sreg[W-1]
    : r_sreg[0];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with Start/Busy/Done handshake.
// ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int Ops = 3,
  parameter int SW  = $clog2(W) + 1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [Ops-1:0] OP,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  output logic           Busy,
  output logic           Done,
  output logic [W-1:0]   Out,
  output logic           Zero,
  output logic           Carry,
  output logic           Parity,
  output logic           Odd
);

  localparam logic [W-1:0]  LP_BMAX = W'(W);
  localparam logic [SW-1:0] LP_KMAX = SW'(W);

  alu_state_t   r_state;
  logic [W-1:0] r_out;
  logic         r_carry;
  logic         r_done;

  alu_op_t      w_op;
  logic [SW-1:0] w_k;
  logic [W-1:0] w_b;
  logic         w_cin;
  logic [W:0]   w_sum;
  logic [W-1:0] w_res;
  logic         w_cout;
  logic         w_cupd;
  logic         w_multi;
  logic [W-1:0] w_sl_val;
  logic [W-1:0] w_sr_val;
  logic         w_sl_c;
  logic         w_sr_c;
  logic         w_sh_busy;
  logic         w_sh_fin;
  logic [W-1:0] w_sh_val;
  logic         w_sh_bit;

  assign w_op = alu_op_t'(OP);

  // Shift amount saturates at W.
  assign w_k = (InputB >= LP_BMAX)
    ? LP_KMAX : InputB[SW-1:0];

  // SUB is A + ~B + 1; ADC folds in the carry.
  assign w_b   = (w_op == ALU_SUB) ? ~InputB : InputB;
  assign w_cin = (w_op == ALU_SUB) ? 1'b1 :
                 (w_op == ALU_ADC) ? r_carry : 1'b0;
  assign w_sum = {1'b0, InputA} + {1'b0, w_b}
               + {{W{1'b0}}, w_cin};

`ifdef ALU_BARREL_SHIFT_EN
  logic [W:0] w_bl;
  logic [W:0] w_br;

  // Extra bit catches the last bit shifted out.
  assign w_bl     = {1'b0, InputA} << w_k;
  assign w_br     = {InputA, 1'b0} >> w_k;
  assign w_sl_val = w_bl[W-1:0];
  assign w_sl_c   = w_bl[W];
  assign w_sr_val = w_br[W:1];
  assign w_sr_c   = w_br[0];
  assign w_multi  = 1'b0;
  assign w_sh_busy = 1'b0;
  assign w_sh_fin  = 1'b0;
  assign w_sh_val  = '0;
  assign w_sh_bit  = 1'b0;
`else
  logic w_load;

  // Single-cycle path only sees shifts with k=0.
  assign w_sl_val = InputA;
  assign w_sr_val = InputA;
  assign w_sl_c   = 1'b0;
  assign w_sr_c   = 1'b0;
  assign w_multi  = is_shift(w_op) && (w_k != '0);
  assign w_load   = (r_state == IDLE) && Start
                  && w_multi;

  alu_shift_unit #(
    .W  (W),
    .SW (SW)
  ) u_shift (
    .i_clk      (Clk),
    .i_reset    (Reset),
    .i_load     (w_load),
    .i_step     (r_state == SHIFT),
    .i_left     (w_op == ALU_SLL),
    .i_din      (InputA),
    .i_amt      (w_k),
    .o_busy     (w_sh_busy),
    .o_finish   (w_sh_fin),
    .o_next     (w_sh_val),
    .o_next_bit (w_sh_bit)
  );
`endif

  // Single-cycle result and carry select.
  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_cupd = 1'b0;
    unique case (w_op)
      ALU_ADD, ALU_ADC, ALU_SUB: begin
        w_res  = w_sum[W-1:0];
        w_cout = w_sum[W];
        w_cupd = 1'b1;
      end
      ALU_SLL: begin
        w_res  = w_sl_val;
        w_cout = w_sl_c;
        w_cupd = (w_k != '0);
      end
      ALU_SRL: begin
        w_res  = w_sr_val;
        w_cout = w_sr_c;
        w_cupd = (w_k != '0);
      end
      ALU_XOR: w_res = InputA ^ InputB;
      ALU_AND: w_res = InputA & InputB;
      ALU_OR:  w_res = InputA | InputB;
      default: w_res = '0;
    endcase
  end

  // Control FSM with registered result, carry and Done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (Start) begin
            if (w_multi) begin
              r_state <= SHIFT;
            end else begin
              r_out  <= w_res;
              r_done <= 1'b1;
              if (w_cupd) r_carry <= w_cout;
            end
          end
        end
        SHIFT: begin
          if (w_sh_fin) begin
            r_out   <= w_sh_val;
            r_carry <= w_sh_bit;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (!w_sh_busy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy   = (r_state == SHIFT);
  assign Done   = r_done;
  assign Out    = r_out;
  assign Carry  = r_carry;
  assign Zero   = (r_out == '0);
  assign Parity = ^r_out;
  assign Odd    = r_out[0];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table plus scoreboard
// for alu_seq at W=8.
module tb_alu_seq;
  import alu_seq_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit ITER = 1'b0;
`else
  localparam bit ITER = 1'b1;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [2:0] OP;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic       Busy;
  logic       Done;
  logic [7:0] Out;
  logic       Zero;
  logic       Carry;
  logic       Parity;
  logic       Odd;

  alu_seq #(.W(8), .Ops(3)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .OP     (OP),
    .InputA (InputA),
    .InputB (InputB),
    .Busy   (Busy),
    .Done   (Done),
    .Out    (Out),
    .Zero   (Zero),
    .Carry  (Carry),
    .Parity (Parity),
    .Odd    (Odd)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] o;
    logic       c;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic       ec;
    int         k;
  } vec_t;

  exp_t sb_q[$];
  exp_t m_e;
  vec_t tv[19];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  // Scoreboard: every Done pops one expected result.
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexp: got Done=1 want none");
      end else begin
        m_e = sb_q.pop_front();
        chk("out", 32'(Out), 32'(m_e.o));
        chk("carry", 32'(Carry), 32'(m_e.c));
        chk("zero", 32'(Zero), 32'(m_e.o == 8'h00));
        chk("parity", 32'(Parity), 32'(^m_e.o));
        chk("odd", 32'(Odd), 32'(m_e.o[0]));
      end
    end
  end

  task automatic run_op(input logic [2:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [7:0] eo,
                        input logic ec,
                        input int lat);
    logic [7:0] prev;
    int busy_n;
    int t;
    prev   = Out;
    Start  = 1'b1;
    OP     = op;
    InputA = a;
    InputB = b;
    sb_q.push_back('{o: eo, c: ec});
    @(posedge Clk); #1;
    Start  = 1'b0;
    busy_n = 0;
    t      = 0;
    while (!Done && t < 40) begin
      if (Busy) busy_n++;
      chk("hold", 32'(Out), 32'(prev));
      @(posedge Clk); #1;
      t++;
    end
    chk("latency", t, lat);
    chk("busy_cycles", busy_n, lat);
    @(posedge Clk); #1;
    chk("done_pulse", 32'(Done), 0);
    chk("busy_idle", 32'(Busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int dn;
    tv[0]  = '{ALU_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 0};
    tv[1]  = '{ALU_ADC, 8'h01, 8'h01, 8'h03, 1'b0, 0};
    tv[2]  = '{ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 0};
    tv[3]  = '{ALU_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 0};
    tv[4]  = '{ALU_SRL, 8'h81, 8'h03, 8'h10, 1'b0, 3};
    tv[5]  = '{ALU_SLL, 8'h81, 8'h01, 8'h02, 1'b1, 1};
    tv[6]  = '{ALU_AND, 8'hFF, 8'h0F, 8'h0F, 1'b1, 0};
    tv[7]  = '{ALU_XOR, 8'hA5, 8'hFF, 8'h5A, 1'b1, 0};
    tv[8]  = '{ALU_OR,  8'h50, 8'h05, 8'h55, 1'b1, 0};
    tv[9]  = '{ALU_ADC, 8'hFF, 8'h00, 8'h00, 1'b1, 0};
    tv[10] = '{ALU_SLL, 8'h3C, 8'h00, 8'h3C, 1'b1, 0};
    tv[11] = '{ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 0};
    tv[12] = '{ALU_SRL, 8'h3C, 8'h00, 8'h3C, 1'b0, 0};
    tv[13] = '{ALU_SLL, 8'hFF, 8'h20, 8'h00, 1'b1, 8};
    tv[14] = '{ALU_SRL, 8'h80, 8'h08, 8'h00, 1'b1, 8};
    tv[15] = '{ALU_SRL, 8'h01, 8'h09, 8'h00, 1'b0, 8};
    tv[16] = '{ALU_SRL, 8'hF0, 8'h04, 8'h0F, 1'b0, 4};
    tv[17] = '{ALU_SLL, 8'h0F, 8'h05, 8'hE0, 1'b1, 5};
    tv[18] = '{ALU_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 0};

    Reset  = 1'b1;
    Start  = 1'b0;
    OP     = 3'd0;
    InputA = 8'h00;
    InputB = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out", 32'(Out), 0);
    chk("rst_carry", 32'(Carry), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_zero", 32'(Zero), 1);
    chk("rst_parity", 32'(Parity), 0);
    chk("rst_odd", 32'(Odd), 0);
    Reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b,
             tv[i].eo, tv[i].ec,
             ITER ? tv[i].k : 0);
    end

`ifndef ALU_BARREL_SHIFT_EN
    // Start during a shift is dropped.
    sb_q.push_back('{o: 8'h10, c: 1'b0});
    Start  = 1'b1;
    OP     = ALU_SRL;
    InputA = 8'h81;
    InputB = 8'h03;
    @(posedge Clk); #1;
    chk("ign_busy", 32'(Busy), 1);
    OP     = ALU_AND;
    InputA = 8'hFF;
    InputB = 8'h0F;
    @(posedge Clk); #1;
    Start = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (Done) dn++;
      @(posedge Clk); #1;
    end
    chk("ign_dones", dn, 1);
    chk("ign_out", 32'(Out), 32'h10);
    run_op(ALU_AND, 8'hFF, 8'h0F, 8'h0F, 1'b0, 0);

    // Reset in the 2nd SHIFT cycle aborts silently.
    run_op(ALU_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 0);
    Start  = 1'b1;
    OP     = ALU_SLL;
    InputA = 8'hFF;
    InputB = 8'h20;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    chk("abt_busy_pre", 32'(Busy), 1);
    chk("abt_out_pre", 32'(Out), 32'h10);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abt_busy", 32'(Busy), 0);
    chk("abt_done", 32'(Done), 0);
    chk("abt_out", 32'(Out), 0);
    chk("abt_carry", 32'(Carry), 0);
    chk("abt_zero", 32'(Zero), 1);
    Reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done) dn++;
      @(posedge Clk); #1;
    end
    chk("abt_no_done", dn, 0);
    run_op(ALU_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 0);
`endif

    @(posedge Clk); #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, parametrised successor to the combinational datapath ALU.
- Executes one operation per Start request and holds the result and status flags in registers.
- Adds a persistent Carry flag, SUB/ADC/OR/SLL, and a multi-cycle iterative shifter with a Start/Busy/Done handshake.
- Sits between the register file read ports and the writeback mux; the controller stalls on Busy.

Parameters:
- W, 8, datapath width in bits (W >= 2).
- Ops, 3, opcode width; only the 8 encodings listed under Behaviour are legal.
- SW, $clog2(W)+1, width of the shift counter; must be able to hold the value W.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- OP  input  Ops  opcode, sampled with Start.
- InputA  input  W  operand A, sampled with Start.
- InputB  input  W  operand B (shift amount for shifts), sampled with Start.
- Busy  output  1  high while a multi-cycle shift is in progress.
- Done  output  1  one-cycle pulse; Out and flags are valid and updated.
- Out  output  W  registered result; holds its value between operations.
- Zero  output  1  (Out == 0).
- Carry  output  1  registered carry/borrow/shift-out flag.
- Parity  output  1  ^Out.
- Odd  output  1  Out[0].

Behaviour:
- Reset: state=IDLE; Out=0; Carry=0; Busy=0; Done=0; shift counter=0. Zero=1, Parity=0, Odd=0 as derived from Out=0. Reset wins over Start and aborts a shift in progress; no Done is issued for the aborted op.
- Opcodes: ADD=0, ADC=1, SUB=2, SLL=3, SRL=4, XOR=5, AND=6, OR=7.
- FSM states: IDLE, SHIFT.
  - IDLE & Start & op not a shift -> compute, register Out, pulse Done; stay IDLE.
  - IDLE & Start & shift op with k=0 -> same single-cycle path.
  - IDLE & Start & shift op with k>0 -> load A into the shift register, count=k, go to SHIFT.
  - SHIFT -> shift 1 bit per edge, count-1; when count reaches 0: write Out, pulse Done, go to IDLE.
- Shift amount: k = min(InputB, W). k >= W yields Out=0.
- Latency, with Start sampled at edge n:
  - Single-cycle ops: Done and new Out visible after edge n.
  - Shift by k>0: Busy high after edges n..n+k-1; Done and new Out visible after edge n+k.
- Busy = (state==SHIFT). Done is registered, high for exactly one cycle.
- Start while Busy=1 is ignored; no queueing.
- Out keeps the previous result during SHIFT. Intermediate shift values never appear on Out.
- Arithmetic is W-bit modulo.
  - ADD: {Carry,Out} = A+B.
  - ADC: {Carry,Out} = A+B+Carry.
  - SUB: {Carry,Out} = A+~B+1, so Carry=1 means no borrow.
  - SLL/SRL are logical with zero fill. Carry = last bit shifted out; unchanged if k=0.
  - XOR/AND/OR leave Carry unchanged.
- Zero, Parity and Odd always track the registered Out. Carry changes only on a Done edge or Reset.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. Every op completes after edge n; Busy is never asserted and the SHIFT state is unused. Out and Carry results are identical to the iterative path.
- Undefined: the iterative 1-bit/cycle shifter described above.

Decomposition:
- Package Definitions:
  - alu_op_t enum (3-bit) with the encodings above; extends the existing op mnemonic enum.
  - alu_state_t enum {IDLE, SHIFT}.
- Sub-module alu_shift_unit:
  - Contents: shift register, down-counter, direction, last-bit-out.
  - Interface: load/busy/finish.
  - Under ALU_BARREL_SHIFT_EN it is replaced by combinational logic.
- The top level holds the FSM, the add/logic paths and the flag registers.

Test Plan (W=8):
- ADD A=0xF0,B=0x20 -> after the Start edge: Out=0x10, Carry=1, Done=1 for 1 cycle. Then ADC A=0x01,B=0x01 -> Out=0x03, Carry=0.
- SUB A=0x05,B=0x05 -> Out=0x00, Zero=1, Carry=1. Then SUB A=0x03,B=0x05 -> Out=0xFE, Carry=0, Parity=1, Odd=0.
- SRL A=0x81,B=3 -> Busy high 3 cycles, Out unchanged meanwhile. Done after edge n+3 with Out=0x10, Carry=0. SLL A=0x81,B=1 -> Out=0x02, Carry=1.
- During that SRL, pulse Start with AND A=0xFF,B=0x0F -> ignored: exactly one Done, Out=0x10. The next AND issued in IDLE gives Out=0x0F.
- SLL A=0xFF,B=0x20 -> k saturates to 8: 8 Busy cycles, Out=0x00, Zero=1, Carry=1. With ALU_BARREL_SHIFT_EN: Done after edge n, Busy never 1.
- Reset asserted on the 2nd SHIFT cycle -> next edge: Busy=0, Done=0, Out=0, Carry=0, Zero=1. No Done follows.
